// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: round-robin arbiter giving a CPU port and a debug port turns on one shared memory
module shared_mem_arbiter #(
   parameter int AW     = 9,
   parameter int DW     = 32,
   parameter int RD_LAT = 1,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cpu_req_i,
   input  logic             cpu_we_i,
   input  logic [AW-1:0]    cpu_addr_i,
   input  logic [DW-1:0]    cpu_wdata_i,
   output logic             cpu_ready_o,
   output logic             cpu_rvalid_o,
   output logic [DW-1:0]    cpu_rdata_o,
   input  logic             dbg_req_i,
   input  logic             dbg_we_i,
   input  logic [AW-1:0]    dbg_addr_i,
   input  logic [DW-1:0]    dbg_wdata_i,
   output logic             dbg_ready_o,
   output logic             dbg_rvalid_o,
   output logic [DW-1:0]    dbg_rdata_o,
   output logic             mem_en_o,
   output logic             mem_we_o,
   output logic [AW-1:0]    mem_addr_o,
   output logic [DW-1:0]    mem_wdata_o,
   input  logic [DW-1:0]    mem_rdata_i,
   output logic             busy_o,
   output logic [CNT_W-1:0] conflict_cnt_o
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   localparam int WW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
   state_t           state_q;
   logic             last_dbg_q, own_dbg_q;
   logic [WW-1:0]    wait_q;
   logic             mem_en_q, mem_we_q, cpu_rvalid_q, dbg_rvalid_q;
   logic [AW-1:0]    mem_addr_q;
   logic [DW-1:0]    mem_wdata_q, cpu_rdata_q, dbg_rdata_q;
   logic [CNT_W-1:0] cnt_q;
   logic             both, win_dbg;
   // Pick the winner: the sole requester, or on a tie the port that was not granted last
   always_comb begin
      both        = cpu_req_i & dbg_req_i;
      win_dbg     = both ? ~last_dbg_q : dbg_req_i;
      cpu_ready_o = (state_q == IDLE) & cpu_req_i & ~win_dbg;
      dbg_ready_o = (state_q == IDLE) & win_dbg;
   end
   // Accept in IDLE, issue one memory command, wait out the read latency, pulse the owner's rvalid
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_dbg_q   <= 1'b1;
         own_dbg_q    <= 1'b0;
         wait_q       <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
         cpu_rvalid_q <= 1'b0;
         dbg_rvalid_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         if (state_q == IDLE && both && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
         case (state_q)
            IDLE: if (cpu_ready_o | dbg_ready_o) begin
               state_q     <= ISSUE;
               own_dbg_q   <= dbg_ready_o;
               last_dbg_q  <= dbg_ready_o;
               mem_en_q    <= 1'b1;
               mem_we_q    <= dbg_ready_o ? dbg_we_i : cpu_we_i;
               mem_addr_q  <= dbg_ready_o ? dbg_addr_i : cpu_addr_i;
               mem_wdata_q <= dbg_ready_o ? dbg_wdata_i : cpu_wdata_i;
            end
            ISSUE: begin
               mem_en_q <= 1'b0;
               mem_we_q <= 1'b0;
               state_q  <= mem_we_q ? IDLE : WAIT;
               wait_q   <= WW'(RD_LAT - 1);
            end
            WAIT: if (wait_q == '0) begin
               state_q      <= RESP;
               cpu_rvalid_q <= ~own_dbg_q;
               dbg_rvalid_q <= own_dbg_q;
               if (own_dbg_q) dbg_rdata_q <= mem_rdata_i;
               else cpu_rdata_q <= mem_rdata_i;
            end else wait_q <= wait_q - WW'(1);
            RESP: begin
               cpu_rvalid_q <= 1'b0;
               dbg_rvalid_q <= 1'b0;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign mem_en_o       = mem_en_q;
   assign mem_we_o       = mem_we_q;
   assign mem_addr_o     = mem_addr_q;
   assign mem_wdata_o    = mem_wdata_q;
   assign cpu_rvalid_o   = cpu_rvalid_q;
   assign dbg_rvalid_o   = dbg_rvalid_q;
   assign cpu_rdata_o    = cpu_rdata_q;
   assign dbg_rdata_o    = dbg_rdata_q;
   assign busy_o         = state_q != IDLE;
   assign conflict_cnt_o = cnt_q;
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb_shared_mem_arbiter: directed checks of arbitration, latency, reset and counter saturation
module tb_shared_mem_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int checks = 0, failures = 0;
   logic a_rst, a_cpu_req, a_cpu_we, a_dbg_req, a_dbg_we;
   logic [8:0] a_cpu_addr, a_dbg_addr, a_mem_addr;
   logic [31:0] a_cpu_wdata, a_dbg_wdata, a_cpu_rdata, a_dbg_rdata, a_mem_wdata, a_mem_rdata;
   logic a_cpu_ready, a_cpu_rvalid, a_dbg_ready, a_dbg_rvalid, a_mem_en, a_mem_we, a_busy;
   logic [15:0] a_cnt;
   logic b_rst, b_cpu_req, b_cpu_we, b_dbg_req, b_dbg_we;
   logic [8:0] b_cpu_addr, b_dbg_addr, b_mem_addr;
   logic [31:0] b_cpu_wdata, b_dbg_wdata, b_cpu_rdata, b_dbg_rdata, b_mem_wdata, b_mem_rdata;
   logic b_cpu_ready, b_cpu_rvalid, b_dbg_ready, b_dbg_rvalid, b_mem_en, b_mem_we, b_busy;
   logic [3:0] b_cnt;
   logic [8:0] pa, pb [3];
   logic va, vb [3];
   logic rv;

   shared_mem_arbiter u_a (
      .clk(clk), .rst(a_rst),
      .cpu_req_i(a_cpu_req), .cpu_we_i(a_cpu_we), .cpu_addr_i(a_cpu_addr), .cpu_wdata_i(a_cpu_wdata),
      .cpu_ready_o(a_cpu_ready), .cpu_rvalid_o(a_cpu_rvalid), .cpu_rdata_o(a_cpu_rdata),
      .dbg_req_i(a_dbg_req), .dbg_we_i(a_dbg_we), .dbg_addr_i(a_dbg_addr), .dbg_wdata_i(a_dbg_wdata),
      .dbg_ready_o(a_dbg_ready), .dbg_rvalid_o(a_dbg_rvalid), .dbg_rdata_o(a_dbg_rdata),
      .mem_en_o(a_mem_en), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata),
      .mem_rdata_i(a_mem_rdata), .busy_o(a_busy), .conflict_cnt_o(a_cnt)
   );

   shared_mem_arbiter #(.RD_LAT(3), .CNT_W(4)) u_b (
      .clk(clk), .rst(b_rst),
      .cpu_req_i(b_cpu_req), .cpu_we_i(b_cpu_we), .cpu_addr_i(b_cpu_addr), .cpu_wdata_i(b_cpu_wdata),
      .cpu_ready_o(b_cpu_ready), .cpu_rvalid_o(b_cpu_rvalid), .cpu_rdata_o(b_cpu_rdata),
      .dbg_req_i(b_dbg_req), .dbg_we_i(b_dbg_we), .dbg_addr_i(b_dbg_addr), .dbg_wdata_i(b_dbg_wdata),
      .dbg_ready_o(b_dbg_ready), .dbg_rvalid_o(b_dbg_rvalid), .dbg_rdata_o(b_dbg_rdata),
      .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata),
      .mem_rdata_i(b_mem_rdata), .busy_o(b_busy), .conflict_cnt_o(b_cnt)
   );

   function automatic logic [31:0] word(input logic [8:0] a);
      return a == 9'h010 ? 32'h8C010004 : 32'hA5000000 | 32'(a);
   endfunction

   // Memory models: data is valid exactly RD_LAT cycles after a read command, poison otherwise
   always @(posedge clk) begin
      va <= a_mem_en & ~a_mem_we;
      pa <= a_mem_addr;
      vb[0] <= b_mem_en & ~b_mem_we;
      pb[0] <= b_mem_addr;
      vb[1] <= vb[0];
      pb[1] <= pb[0];
      vb[2] <= vb[1];
      pb[2] <= pb[1];
   end
   assign a_mem_rdata = va ? word(pa) : 32'hBAD0BAD0;
   assign b_mem_rdata = vb[2] ? word(pb[2]) : 32'hBAD0BAD0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #2;
   endtask

   initial begin
      {a_cpu_req, a_cpu_we, a_dbg_req, a_dbg_we, b_cpu_req, b_cpu_we, b_dbg_req, b_dbg_we} = '0;
      {a_cpu_addr, a_dbg_addr, b_cpu_addr, b_dbg_addr} = '0;
      {a_cpu_wdata, a_dbg_wdata, b_cpu_wdata, b_dbg_wdata} = '0;
      a_rst = 1'b1;
      b_rst = 1'b1;
      step;
      step;
      a_rst = 1'b0;
      step;
      chk("rst_busy", a_busy, 0);
      chk("rst_mem", {a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata}, 0);
      chk("rst_rdata", {a_cpu_rdata, a_dbg_rdata}, 0);
      chk("rst_rv_rdy", {a_cpu_rvalid, a_dbg_rvalid, a_cpu_ready, a_dbg_ready}, 0);
      chk("rst_cnt", a_cnt, 0);
      // CPU read, RD_LAT=1
      a_cpu_req = 1'b1;
      a_cpu_addr = 9'h010;
      #1 chk("t1_ready", {a_cpu_ready, a_dbg_ready}, 2'b10);
      step;
      a_cpu_req = 1'b0;
      #1 chk("t1_issue", {a_mem_en, a_mem_we, a_mem_addr}, {1'b1, 1'b0, 9'h010});
      step;
      chk("t1_wait", {a_mem_en, a_cpu_rvalid, a_busy}, 3'b001);
      step;
      chk("t1_rvalid", {a_cpu_rvalid, a_dbg_rvalid}, 2'b10);
      chk("t1_rdata", a_cpu_rdata, 32'h8C010004);
      step;
      chk("t1_done", {a_cpu_rvalid, a_busy}, 2'b00);
      chk("t1_hold", a_cpu_rdata, 32'h8C010004);
      // DBG write
      a_dbg_req = 1'b1;
      a_dbg_we = 1'b1;
      a_dbg_addr = 9'h1FF;
      a_dbg_wdata = 32'hDEADBEEF;
      #1 chk("t2_ready", {a_cpu_ready, a_dbg_ready}, 2'b01);
      step;
      a_dbg_req = 1'b0;
      a_dbg_we = 1'b0;
      #1 chk("t2_issue", {a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata}, {2'b11, 9'h1FF, 32'hDEADBEEF});
      chk("t2_rv1", {a_cpu_rvalid, a_dbg_rvalid}, 0);
      step;
      chk("t2_idle", {a_busy, a_mem_en, a_mem_we, a_cpu_rvalid, a_dbg_rvalid}, 0);
      chk("t2_addr_hold", a_mem_addr, 9'h1FF);
      // Both ports reading continuously from reset
      a_rst = 1'b1;
      step;
      a_rst = 1'b0;
      a_cpu_req = 1'b1;
      a_dbg_req = 1'b1;
      a_cpu_addr = 9'h020;
      a_dbg_addr = 9'h030;
      for (int i = 0; i < 4; i++) begin
         #1 chk("t3_grant", {a_cpu_ready, a_dbg_ready}, i % 2 == 0 ? 2'b10 : 2'b01);
         step;
         step;
         step;
         chk("t3_rvalid", {a_cpu_rvalid, a_dbg_rvalid}, i % 2 == 0 ? 2'b10 : 2'b01);
         chk("t3_rdata", i % 2 == 0 ? a_cpu_rdata : a_dbg_rdata, i % 2 == 0 ? word(9'h020) : word(9'h030));
         step;
      end
      chk("t3_cnt", a_cnt, 4);
      a_cpu_req = 1'b0;
      a_dbg_req = 1'b0;
      step;
      // Reset asserted while a read waits on memory
      a_cpu_req = 1'b1;
      a_cpu_addr = 9'h010;
      step;
      a_cpu_req = 1'b0;
      step;
      a_rst = 1'b1;
      step;
      a_rst = 1'b0;
      chk("t5_state", {a_busy, a_mem_en, a_cpu_rvalid, a_dbg_rvalid}, 0);
      chk("t5_rdata", {a_cpu_rdata, a_dbg_rdata}, 0);
      chk("t5_cnt", a_cnt, 0);
      rv = 1'b0;
      repeat (5) begin
         step;
         rv |= a_cpu_rvalid | a_dbg_rvalid;
      end
      chk("t5_no_rvalid", rv, 0);
      // RD_LAT=3 CPU read with debug waiting
      b_rst = 1'b0;
      step;
      b_cpu_req = 1'b1;
      b_cpu_addr = 9'h044;
      b_dbg_req = 1'b1;
      b_dbg_we = 1'b1;
      b_dbg_addr = 9'h0AA;
      b_dbg_wdata = 32'h12345678;
      #1 chk("t4_ready", {b_cpu_ready, b_dbg_ready}, 2'b10);
      step;
      b_cpu_req = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         #1 chk("t4_rdy_low", {b_cpu_ready, b_dbg_ready}, 0);
         chk("t4_mem_en", b_mem_en, k == 1);
         chk("t4_rvalid", b_cpu_rvalid, k == 5);
         if (k == 5) chk("t4_rdata", b_cpu_rdata, word(9'h044));
         step;
      end
      chk("t4_next", {b_cpu_ready, b_dbg_ready}, 2'b01);
      step;
      b_dbg_req = 1'b0;
      step;
      // Counter saturation with CNT_W=4 under continuous conflicting writes
      b_rst = 1'b1;
      step;
      b_rst = 1'b0;
      b_cpu_we = 1'b1;
      b_cpu_req = 1'b1;
      b_dbg_req = 1'b1;
      repeat (28) step;
      #1 chk("t6_cnt14", b_cnt, 14);
      chk("t6_grant", {b_cpu_ready, b_dbg_ready}, 2'b10);
      repeat (4) step;
      chk("t6_sat", b_cnt, 15);
      repeat (8) step;
      chk("t6_nowrap", b_cnt, 15);
      b_cpu_req = 1'b0;
      b_dbg_req = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
